// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV unit for the multicycle MIPS core.
// Operands are latched as magnitudes plus sign flags. Each edge performs one
// shift-add (MULT) or restoring shift-subtract (DIV) step in a shared
// 2*WIDTH accumulator. A final FIX cycle applies the signs and writes HI/LO.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MULT = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state;
  logic [CW-1:0]      cnt;
  logic               op_div;
  logic               sa, sb;
  logic [WIDTH-1:0]   mb;
  // MULT: {partial product high, multiplier shifting out}
  // DIV : {remainder, dividend shifting out / quotient shifting in}
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_up;
  logic [2*WIDTH-1:0] acc_mul_nxt;
  logic [WIDTH:0]     div_tmp, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_div_nxt;
  logic [2*WIDTH-1:0] prod_mag, prod_s;
  logic [WIDTH-1:0]   quo_mag, rem_mag, quo_s, rem_s;

  assign busy = (state == S_MULT) || (state == S_DIV) || (state == S_FIX);
  assign done = (state == S_DONE);

  // Datapath: operand magnitudes, one iteration step, and sign correction.
  always_comb begin
    mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;
    // Shift-add: add the multiplicand into the top half when the LSB is set,
    // then shift right so the next multiplier bit lands in acc[0].
    mul_up      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mb} : '0);
    acc_mul_nxt = {mul_up, acc[WIDTH-1:1]};
    // Restoring divide. The remainder is always below the divisor, so bit
    // WIDTH of the difference is a clean borrow flag.
    div_tmp     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff    = div_tmp - {1'b0, mb};
    div_ge      = ~div_diff[WIDTH];
    acc_div_nxt = {(div_ge ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0]),
                   acc[WIDTH-2:0], div_ge};
    // The MIN_INT / -1 quotient magnitude is 2^(W-1). It has a positive sign,
    // so it passes through unchanged and wraps to MIN_INT.
    prod_mag = acc;
    quo_mag  = acc[WIDTH-1:0];
    rem_mag  = acc[2*WIDTH-1:WIDTH];
    prod_s   = (sa ^ sb) ? (~prod_mag + 1'b1) : prod_mag;
    quo_s    = (sa ^ sb) ? (~quo_mag + 1'b1) : quo_mag;
    rem_s    = sa ? (~rem_mag + 1'b1) : rem_mag;
  end

  // Control FSM plus iteration registers and the HI/LO result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_div      <= 1'b0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      mb          <= '0;
      acc         <= '0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_mult || start_div) begin
            cnt <= '0;
            sa  <= a[WIDTH-1];
            sb  <= b[WIDTH-1];
            mb  <= mag_b;
            acc <= {{WIDTH{1'b0}}, mag_a};
            if (start_mult) begin
              op_div      <= 1'b0;
              div_by_zero <= 1'b0;
              state       <= S_MULT;
            end else if (b == '0) begin
              op_div      <= 1'b1;
              div_by_zero <= 1'b1;
              state       <= S_DONE;
            end else begin
              op_div      <= 1'b1;
              div_by_zero <= 1'b0;
              state       <= S_DIV;
            end
          end
        end
        S_MULT, S_DIV: begin
          acc <= (state == S_DIV) ? acc_div_nxt : acc_mul_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= S_FIX;
        end
        S_FIX: begin
          if (op_div) begin
            lo <= quo_s;
            hi <= rem_s;
          end else begin
            {hi, lo} <= prod_s;
          end
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit. The stimulus pushes the expected
// {hi, lo, div_by_zero} into a queue for each operation. An independent
// monitor pops and compares an entry whenever done is seen.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_mult = 1'b0, start_div = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_mult(start_mult), .start_div(start_div),
    .a(a), .b(b), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare the result presented with each done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst && done) begin
      if (sbq.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else begin
        e = sbq.pop_front();
        check("hi", {32'd0, hi}, {32'd0, e.hi});
        check("lo", {32'd0, lo}, {32'd0, e.lo});
        check("dbz", {63'd0, div_by_zero}, {63'd0, e.dbz});
      end
    end
  end

  // Called at a negedge with state IDLE. Start is seen at edge k. For i=0..lat,
  // the cycle after edge k+i must show busy=(i<lat) and done=(i==lat). The
  // cycle after that must be idle. Operands are scrambled while busy, and
  // start_mult can be pulsed so that it is sampled at edge k+inj.
  // The task returns at the negedge of the first IDLE cycle after DONE.
  task automatic run_op(input logic m, input logic d, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input int lat, input int inj,
                        input exp_t e);
    int bad;
    bad = 0;
    start_mult = m; start_div = d; a = aa; b = bb;
    sbq.push_back(e);
    @(posedge clk);
    for (int i = 0; i <= lat; i++) begin
      @(negedge clk);
      start_mult = 1'b0; start_div = 1'b0;
      if (i == 1) begin a = $urandom; b = $urandom; end
      if (inj > 0 && i == inj - 1) start_mult = 1'b1;
      if (done !== (i == lat) || busy !== (i < lat)) bad++;
    end
    @(negedge clk);
    if (done !== 1'b0 || busy !== 1'b0) bad++;
    check("timing", 64'(bad), 64'd0);
  endtask

  initial begin
    #2;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Signed multiply: 7 * -3 = -21.
    run_op(1, 0, 32'd7, 32'hFFFFFFFD, 33, 0, '{32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0});
    // Truncating divide; the remainder takes the dividend's sign.
    run_op(0, 1, 32'hFFFFFFF9, 32'd2, 33, 0, '{32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
    run_op(0, 1, 32'd7, 32'hFFFFFFFE, 33, 0, '{32'h00000001, 32'hFFFFFFFD, 1'b0});
    run_op(0, 1, 32'hFFFFFF9C, 32'hFFFFFFF9, 33, 0, '{32'hFFFFFFFE, 32'h0000000E, 1'b0});
    // MIN_INT / -1 wraps with no flag; MIN_INT * -1 = +2^31.
    run_op(0, 1, 32'h80000000, 32'hFFFFFFFF, 33, 0, '{32'h0, 32'h80000000, 1'b0});
    run_op(1, 0, 32'h80000000, 32'hFFFFFFFF, 33, 0, '{32'h0, 32'h80000000, 1'b0});
    run_op(1, 0, 32'h80000000, 32'h80000000, 33, 0, '{32'h40000000, 32'h0, 1'b0});
    // 6 * 0x2AAAAAAB = 0x1_00000002 leaves hi=1, lo=2.
    run_op(1, 0, 32'd6, 32'h2AAAAAAB, 33, 0, '{32'h1, 32'h2, 1'b0});
    // Divide by zero: done right after the start edge, hi/lo untouched.
    run_op(0, 1, 32'd5, 32'd0, 0, 0, '{32'h1, 32'h2, 1'b1});
    // Both starts with b=0: the multiply wins and clears the flag.
    run_op(1, 1, 32'd5, 32'd0, 33, 0, '{32'h0, 32'h0, 1'b0});
    // A start_mult sampled at edge k+10 of a divide is ignored.
    run_op(0, 1, 32'd100, 32'd7, 33, 10, '{32'h2, 32'hE, 1'b0});
    // Both starts: multiply -4 * 5.
    run_op(1, 1, 32'hFFFFFFFC, 32'd5, 33, 0, '{32'hFFFFFFFF, 32'hFFFFFFEC, 1'b0});

    // Reset 15 edges into a multiply clears everything at once.
    start_mult = 1'b1; a = 32'd9; b = 32'd9;
    @(posedge clk);
    @(negedge clk); start_mult = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    run_op(1, 0, 32'd3, 32'd4, 33, 0, '{32'h0, 32'hC, 1'b0});

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
